// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the serial BCD/binary adder
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam int DIGIT_W = 4;

    // Decimal correction terms: +6 after an add that overflows a digit,
    // +10 (i.e. -6 mod 16) after a subtract that borrowed.
    localparam logic [DIGIT_W-1:0] BCD_ADJ_ADD = 4'h6;
    localparam logic [DIGIT_W-1:0] BCD_ADJ_SUB = 4'hA;

endpackage

// File: rtl/bcd_digit_slice.sv
// rtl/bcd_digit_slice.sv - combinational one-digit binary/BCD add/subtract slice
//
// Ports:
//   a, b   : operand nibbles (b is inverted internally when add=0)
//   c      : carry in to this digit
//   add    : 1 = a+b+c, 0 = a+~b+c
//   bcd    : 1 = apply decimal correction
//   s      : corrected digit result
//   carry  : digit carry out (decimal carry in BCD mode, binary otherwise)
//   bs3    : bit 3 of the uncorrected sum, for signed overflow
//   b2_3   : bit 3 of the (possibly inverted) b operand, for signed overflow
module bcd_digit_slice
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               c,
    input  logic               add,
    input  logic               bcd,
    output logic [DIGIT_W-1:0] s,
    output logic               carry,
    output logic               bs3,
    output logic               b2_3
);

    logic [DIGIT_W-1:0] b2;
    logic [DIGIT_W:0]   sum;
    logic [DIGIT_W-1:0] bs;
    logic               bc;
    logic               dc;

    always_comb begin
        b2  = b ^ {DIGIT_W{~add}};
        sum = {1'b0, a} + {1'b0, b2} + {{DIGIT_W{1'b0}}, c};
        bc  = sum[DIGIT_W];
        bs  = sum[DIGIT_W-1:0];
        s   = bs;
        if (add) begin
            // Decimal carry when the binary sum exceeds 9.
            dc = bc | (bs[3] & (bs[2] | bs[1]));
            if (bcd && dc) begin
                s = bs + BCD_ADJ_ADD;
            end
        end else begin
            // For subtraction a missing carry means a borrow occurred.
            dc = bc;
            if (bcd && !dc) begin
                s = bs + BCD_ADJ_SUB;
            end
        end
        carry = bcd ? dc : bc;
        bs3   = bs[3];
        b2_3  = b2[3];
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial binary/BCD adder-subtractor with C/V/Z/N flags
//
// Processes one 4-bit digit per clock, least significant digit first.
// Optional build macro BCD_SERIAL_ZN_EN: when defined, ZO/NO are computed at
// FIN; when undefined they are tied to 0 and the zero/negative logic is absent.
//
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   START         : operation request, accepted only in IDLE
//   A, B          : operands (W bits)
//   CI            : carry in (1 = no borrow when subtracting)
//   ADD           : 1 = A+B+CI, 0 = A+~B+CI
//   BCD           : 1 = decimal correction per digit
//   LEN           : active digit count; 0 or above DIGITS means DIGITS
//   BUSY          : high while digits are being processed
//   DONE          : one-cycle pulse when S and flags are valid
//   S             : result; digits at or above LEN read 0
//   CO, VO        : carry / signed overflow of the top active digit
//   ZO, NO        : active result is zero / top active bit of S
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int LW     = $clog2(DIGITS + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  CI,
    input  logic                  ADD,
    input  logic                  BCD,
    input  logic [LW-1:0]         LEN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   S,
    output logic                  CO,
    output logic                  VO,
    output logic                  ZO,
    output logic                  NO
);

    localparam int W = DIGIT_W * DIGITS;
    localparam logic [LW-1:0] DIGITS_L = LW'(DIGITS);

    state_t              state;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic                add_q;
    logic                bcd_q;
    logic [LW-1:0]       len_q;
    logic [LW-1:0]       idx;
    logic                carry_q;
    logic                v_q;

    logic [LW-1:0]       len_eff;
    logic [LW+1:0]       shamt;
    logic [DIGIT_W-1:0]  a_dig;
    logic [DIGIT_W-1:0]  b_dig;
    logic [DIGIT_W-1:0]  d_s;
    logic                d_c;
    logic                d_bs3;
    logic                d_b2_3;
    logic                d_v;
    logic                last_dig;

    assign len_eff  = ((LEN == '0) || (LEN > DIGITS_L)) ? DIGITS_L : LEN;
    assign shamt    = {idx, 2'b00};
    assign a_dig    = DIGIT_W'(a_q >> shamt);
    assign b_dig    = DIGIT_W'(b_q >> shamt);
    assign last_dig = (idx == (len_q - LW'(1)));
    assign d_v      = ~(a_dig[3] ^ d_b2_3) & (a_dig[3] ^ d_bs3);

    bcd_digit_slice u_slice (
        .a     (a_dig),
        .b     (b_dig),
        .c     (carry_q),
        .add   (add_q),
        .bcd   (bcd_q),
        .s     (d_s),
        .carry (d_c),
        .bs3   (d_bs3),
        .b2_3  (d_b2_3)
    );

`ifdef BCD_SERIAL_ZN_EN
    logic [LW+1:0] n_pos;
    logic [W-1:0]  n_mask;

    // Digits above LEN stay zero for the whole operation, so a full-width
    // zero test on S equals the zero test of the active slice.
    assign n_pos  = {len_q, 2'b00} - (LW+2)'(1);
    assign n_mask = {{(W-1){1'b0}}, 1'b1} << n_pos;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ZO <= 1'b0;
            NO <= 1'b0;
        end else if (state == FIN) begin
            ZO <= (S == '0);
            NO <= |(S & n_mask);
        end
    end
`else
    assign ZO = 1'b0;
    assign NO = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            add_q   <= 1'b0;
            bcd_q   <= 1'b0;
            len_q   <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            v_q     <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            S       <= '0;
            CO      <= 1'b0;
            VO      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        a_q     <= A;
                        b_q     <= B;
                        add_q   <= ADD;
                        bcd_q   <= BCD;
                        len_q   <= len_eff;
                        idx     <= '0;
                        carry_q <= CI;
                        S       <= '0;
                        BUSY    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    S       <= (S & ~({{(W-DIGIT_W){1'b0}}, 4'hF} << shamt))
                             | ({{(W-DIGIT_W){1'b0}}, d_s} << shamt);
                    carry_q <= d_c;
                    v_q     <= d_v;
                    idx     <= idx + LW'(1);
                    if (last_dig) begin
                        BUSY  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    DONE  <= 1'b1;
                    CO    <= carry_q;
                    VO    <= v_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
